// File: rtl/multicycle_ctrl_if.sv
// Memory request/acknowledge port shared by instruction fetch and data access.
// The controller is the master: it drives the request, the bus drives the ack and data.
interface multicycle_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the 16-bit RISC: fetches into IR, sequences
// FETCH/DECODE/EXE/MEM/WB and owns PC, PSW and MDR.
module multicycle_ctrl #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic                    clk,
    input  logic                    Reset,
    multicycle_ctrl_if.master       mem,
    input  logic [15:0]             Sum,
    input  logic                    C,
    input  logic                    Z,
    input  logic                    N,
    output logic [10:0]             Ins,
    output logic [15:0]             MEMData,
    output logic                    WBRF,
    output logic                    WBresource,
    output logic                    RBresource,
    output logic                    OprandB,
    output logic                    LI,
    output logic                    Buff_OutR,
    output logic                    ALUop,
    output logic                    Flag,
    output logic                    WBsrc,
    output logic                    PSW_C,
    output logic                    PSW_Z,
    output logic                    PSW_N,
    output logic [15:0]             PC,
    output logic                    halted,
    output logic                    illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXE,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [4:0] OP_NOP  = 5'b00000;
    localparam logic [4:0] OP_ADD  = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_ADC  = 5'b00011;
    localparam logic [4:0] OP_SBB  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUBI = 5'b00110;
    localparam logic [4:0] OP_LHI  = 5'b00111;
    localparam logic [4:0] OP_LLI  = 5'b01000;
    localparam logic [4:0] OP_LD   = 5'b01001;
    localparam logic [4:0] OP_ST   = 5'b01010;
    localparam logic [4:0] OP_OUT  = 5'b01011;
    localparam logic [4:0] OP_CMP  = 5'b01100;
    localparam logic [4:0] OP_BZ   = 5'b01101;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] mdr_q, mdr_d;
    logic [2:0]  psw_q, psw_d;

    logic [4:0]  opcode;
    logic        isAlu;
    logic        isLegal;
    logic        decOprandB, decRBresource, decLI, decALUop, decFlag, decWBsrc, decWBresource;
    logic        ctrlActive;

    assign opcode = ir_q[15:11];

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            mdr_q   <= '0;
            psw_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            psw_q   <= psw_d;
        end
    end

    // Instruction decode is purely a function of IR, so the controls stay stable all instruction long.
    always_comb begin
        isAlu         = 1'b0;
        isLegal       = 1'b1;
        decOprandB    = 1'b0;
        decRBresource = 1'b0;
        decLI         = 1'b0;
        decALUop      = 1'b0;
        decFlag       = 1'b0;
        decWBsrc      = 1'b0;
        decWBresource = 1'b0;
        case (opcode)
            OP_NOP:  ;
            OP_ADD:  isAlu = 1'b1;
            OP_SUB:  begin isAlu = 1'b1; decALUop = 1'b1; end
            OP_ADC:  begin isAlu = 1'b1; decFlag = 1'b1; end
            OP_SBB:  begin isAlu = 1'b1; decALUop = 1'b1; decFlag = 1'b1; end
            OP_ADDI: begin isAlu = 1'b1; decOprandB = 1'b1; end
            OP_SUBI: begin isAlu = 1'b1; decOprandB = 1'b1; decALUop = 1'b1; end
            OP_LHI:  begin decLI = 1'b1; decRBresource = 1'b1; decWBsrc = 1'b1; end
            OP_LLI:  decWBsrc = 1'b1;
            OP_LD:   begin decOprandB = 1'b1; decWBresource = 1'b1; end
            OP_ST:   begin decOprandB = 1'b1; decRBresource = 1'b1; end
            OP_OUT:  ;
            OP_CMP:  decALUop = 1'b1;
            OP_BZ:   ;
            OP_HLT:  ;
            default: isLegal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        psw_d   = psw_q;
        case (state_q)
            S_FETCH: begin
                if (mem.mem_ack) begin
                    ir_d    = mem.mem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!isLegal || opcode == OP_NOP || opcode == OP_OUT) begin
                    state_d = S_FETCH;
                end else if (opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                state_d = S_FETCH;
                if (isAlu || opcode == OP_LHI || opcode == OP_LLI) begin
                    state_d = S_WB;
                end else if (opcode == OP_LD || opcode == OP_ST) begin
                    state_d = S_MEM;
                end else if (opcode == OP_CMP) begin
                    psw_d = {C, Z, N};
                end else if (opcode == OP_BZ && psw_q[1]) begin
                    pc_d = pc_q + {{8{ir_q[7]}}, ir_q[7:0]};
                end
            end
            S_MEM: begin
                if (mem.mem_ack) begin
                    if (opcode == OP_LD) begin
                        mdr_d   = mem.mem_rdata;
                        state_d = S_WB;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                // Flags are committed here, not in EXE, so ADC/SBB keep a stable carry-in until the RF write.
                if (isAlu) begin
                    psw_d = {C, Z, N};
                end
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // The request is gated by the reset input itself so an aborted access drops without waiting for a clock.
    assign mem.mem_req  = Reset && (state_q == S_FETCH || state_q == S_MEM);
    assign mem.mem_we   = Reset && (state_q == S_MEM) && (opcode == OP_ST);
    assign mem.mem_addr = (state_q == S_MEM) ? Sum : pc_q;

    assign ctrlActive = (state_q == S_DECODE) || (state_q == S_EXE) ||
                        (state_q == S_MEM)    || (state_q == S_WB);

    assign OprandB    = ctrlActive && decOprandB;
    assign RBresource = ctrlActive && decRBresource;
    assign LI         = ctrlActive && decLI;
    assign ALUop      = ctrlActive && decALUop;
    assign Flag       = ctrlActive && decFlag;
    assign WBsrc      = ctrlActive && decWBsrc;
    assign WBresource = ctrlActive && decWBresource;

    assign WBRF      = (state_q == S_WB);
    assign Buff_OutR = (state_q == S_DECODE) && (opcode == OP_OUT);
    assign illegal   = (state_q == S_DECODE) && !isLegal;
    assign halted    = (state_q == S_HALT);

    assign Ins     = ir_q[10:0];
    assign MEMData = mdr_q;
    assign PC      = pc_q;
    assign PSW_C   = psw_q[2];
    assign PSW_Z   = psw_q[1];
    assign PSW_N   = psw_q[0];

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random-program bench for multicycle_ctrl: an ISA-level model predicts memory
// transactions, writebacks, OUT and illegal events; monitors compare as they occur.
module tb_multicycle_ctrl;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [2:0]  psw;
    } memExp_t;

    typedef struct {
        logic [6:0]  ctrl;
        logic [10:0] ins;
        logic [15:0] mdr;
        bit          chkMdr;
    } wbExp_t;

    typedef struct {
        int          waitc;
        logic [15:0] rdata;
        bit          isFetch;
        logic [15:0] sum;
        logic [2:0]  flags;
    } resp_t;

    logic        clk = 1'b0;
    logic        Reset;
    logic [15:0] Sum;
    logic        C, Z, N;
    logic [10:0] Ins;
    logic [15:0] MEMData;
    logic        WBRF, WBresource, RBresource, OprandB, LI, Buff_OutR, ALUop, Flag, WBsrc;
    logic        PSW_C, PSW_Z, PSW_N;
    logic [15:0] PC;
    logic        halted, illegal;

    int checks   = 0;
    int failures = 0;
    bit monEnable = 1'b0;

    memExp_t     memQ[$];
    wbExp_t      wbQ[$];
    logic [10:0] outQ[$];
    logic [10:0] illQ[$];
    resp_t       respQ[$];

    multicycle_ctrl_if memBus();

    multicycle_ctrl #(.PC_RESET(16'h0000)) dut (
        .clk(clk), .Reset(Reset), .mem(memBus),
        .Sum(Sum), .C(C), .Z(Z), .N(N),
        .Ins(Ins), .MEMData(MEMData),
        .WBRF(WBRF), .WBresource(WBresource), .RBresource(RBresource),
        .OprandB(OprandB), .LI(LI), .Buff_OutR(Buff_OutR),
        .ALUop(ALUop), .Flag(Flag), .WBsrc(WBsrc),
        .PSW_C(PSW_C), .PSW_Z(PSW_Z), .PSW_N(PSW_N),
        .PC(PC), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: DUT event with nothing expected", name);
    endtask

    // Controls expected at writeback: {WBresource, WBsrc, LI, RBresource, OprandB, ALUop, Flag}.
    function automatic logic [6:0] wbCtrl(input logic [4:0] op);
        case (op)
            5'd1:    return 7'b000_0000;
            5'd2:    return 7'b000_0010;
            5'd3:    return 7'b000_0001;
            5'd4:    return 7'b000_0011;
            5'd5:    return 7'b000_0100;
            5'd6:    return 7'b000_0110;
            5'd7:    return 7'b011_1000;
            5'd8:    return 7'b010_0000;
            5'd9:    return 7'b100_0100;
            default: return 7'b000_0000;
        endcase
    endfunction

    // Builds a random executed trace of n instructions plus a final HLT, running the ISA model alongside.
    task automatic applyStimulus(input int n);
        int          opTable[20];
        logic [15:0] pc;
        logic [2:0]  psw;
        logic [4:0]  op;
        logic [31:0] r;
        logic [15:0] word;
        memExp_t     m;
        wbExp_t      w;
        resp_t       rs;
        opTable = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 10, 10, 11, 12, 12, 13, 13, 21, 14};
        pc  = 16'h0000;
        psw = 3'b000;
        for (int k = 0; k <= n; k++) begin
            op   = (k == n) ? 5'b11111 : 5'(opTable[$urandom_range(0, 19)]);
            r    = $urandom();
            word = {op, r[10:0]};
            rs.waitc   = $urandom_range(0, 3);
            rs.rdata   = word;
            rs.isFetch = 1'b1;
            rs.sum     = 16'($urandom());
            rs.flags   = 3'($urandom());
            respQ.push_back(rs);
            m.addr = pc; m.we = 1'b0; m.psw = psw;
            memQ.push_back(m);
            pc = pc + 16'd1;
            w.ctrl = wbCtrl(op); w.ins = word[10:0]; w.mdr = 16'h0; w.chkMdr = 1'b0;
            if (op >= 5'd1 && op <= 5'd6) begin
                wbQ.push_back(w);
                psw = rs.flags;
            end else if (op == 5'd7 || op == 5'd8) begin
                wbQ.push_back(w);
            end else if (op == 5'd9 || op == 5'd10) begin
                m.addr = rs.sum; m.we = (op == 5'd10); m.psw = psw;
                memQ.push_back(m);
                rs.waitc   = $urandom_range(0, 3);
                rs.rdata   = 16'($urandom());
                rs.isFetch = 1'b0;
                respQ.push_back(rs);
                if (op == 5'd9) begin
                    w.mdr = rs.rdata; w.chkMdr = 1'b1;
                    wbQ.push_back(w);
                end
            end else if (op == 5'd11) begin
                outQ.push_back(word[10:0]);
            end else if (op == 5'd12) begin
                psw = rs.flags;
            end else if (op == 5'd13) begin
                if (psw[1]) pc = pc + {{8{word[7]}}, word[7:0]};
            end else if (op != 5'd0 && op != 5'd31) begin
                illQ.push_back(word[10:0]);
            end
        end
    endtask

    // Memory responder: random wait states, and loads the datapath inputs for each instruction at its fetch.
    initial begin
        int cnt;
        resp_t rs;
        cnt = 0;
        memBus.mem_ack = 1'b0; memBus.mem_rdata = 16'h0;
        Sum = 16'h0; C = 1'b0; Z = 1'b0; N = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!Reset) begin
                cnt = 0;
                memBus.mem_ack = 1'b0;
            end else if (memBus.mem_req && respQ.size() > 0) begin
                if (cnt >= respQ[0].waitc) begin
                    rs = respQ.pop_front();
                    memBus.mem_ack   = 1'b1;
                    memBus.mem_rdata = rs.rdata;
                    if (rs.isFetch) begin
                        Sum = rs.sum;
                        {C, Z, N} = rs.flags;
                    end
                    cnt = 0;
                end else begin
                    memBus.mem_ack = 1'b0;
                    cnt++;
                end
            end else begin
                memBus.mem_ack = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT shows a transaction or event.
    bit          holdPending = 1'b0;
    logic [15:0] holdAddr;
    logic        holdWe;
    memExp_t     me;
    wbExp_t      we;
    logic [10:0] ie;
    always @(negedge clk) begin
        if (monEnable && Reset) begin
            if (memBus.mem_req) begin
                if (holdPending) begin
                    checkOutput("hold_addr", memBus.mem_addr, holdAddr);
                    checkOutput("hold_we", memBus.mem_we, holdWe);
                end
                holdPending = !memBus.mem_ack;
                holdAddr = memBus.mem_addr;
                holdWe   = memBus.mem_we;
            end else begin
                holdPending = 1'b0;
            end
            if (memBus.mem_req && memBus.mem_ack) begin
                if (memQ.size() == 0) unexpected("mem_txn");
                else begin
                    me = memQ.pop_front();
                    checkOutput("txn_addr", memBus.mem_addr, me.addr);
                    checkOutput("txn_we", memBus.mem_we, me.we);
                    checkOutput("txn_psw", {PSW_C, PSW_Z, PSW_N}, me.psw);
                end
            end
            if (WBRF) begin
                if (wbQ.size() == 0) unexpected("wb");
                else begin
                    we = wbQ.pop_front();
                    checkOutput("wb_ctrl", {WBresource, WBsrc, LI, RBresource, OprandB, ALUop, Flag}, we.ctrl);
                    checkOutput("wb_ins", Ins, we.ins);
                    if (we.chkMdr) checkOutput("wb_mdr", MEMData, we.mdr);
                end
            end
            if (Buff_OutR) begin
                if (outQ.size() == 0) unexpected("out");
                else begin
                    ie = outQ.pop_front();
                    checkOutput("out_ins", Ins, ie);
                end
            end
            if (illegal) begin
                if (illQ.size() == 0) unexpected("illegal");
                else begin
                    ie = illQ.pop_front();
                    checkOutput("illegal_ins", Ins, ie);
                end
            end
        end else begin
            holdPending = 1'b0;
        end
    end

    initial begin
        int    cyc;
        resp_t rs;
        Reset = 1'b0;
        applyStimulus(80);
        monEnable = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_mem_req", memBus.mem_req, 0);
        checkOutput("rst_mem_addr", memBus.mem_addr, 16'h0000);
        checkOutput("rst_pc", PC, 16'h0000);
        checkOutput("rst_psw", {PSW_C, PSW_Z, PSW_N}, 0);
        checkOutput("rst_ins", Ins, 0);
        checkOutput("rst_mdr", MEMData, 0);
        checkOutput("rst_strobes", {WBRF, Buff_OutR, OprandB, LI, halted, illegal}, 0);
        Reset = 1'b1;
        @(negedge clk);
        checkOutput("req_after_release", memBus.mem_req, 1);

        cyc = 0;
        while (!halted && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("halt_reached", halted, 1);
        repeat (10) @(negedge clk);
        checkOutput("halted_stays", halted, 1);
        checkOutput("halted_no_req", memBus.mem_req, 0);
        checkOutput("memQ_drained", memQ.size(), 0);
        checkOutput("wbQ_drained", wbQ.size(), 0);
        checkOutput("outQ_drained", outQ.size(), 0);
        checkOutput("illQ_drained", illQ.size(), 0);

        // Abort an LD that is stalled in its data access by asserting reset mid-cycle.
        monEnable = 1'b0;
        Reset = 1'b0;
        #1;
        memQ.delete(); wbQ.delete(); outQ.delete(); illQ.delete(); respQ.delete();
        rs.waitc = 0; rs.rdata = 16'h4820; rs.isFetch = 1'b1; rs.sum = 16'h0040; rs.flags = 3'b000;
        respQ.push_back(rs);
        rs.waitc = 1000; rs.rdata = 16'hBEEF; rs.isFetch = 1'b0;
        respQ.push_back(rs);
        @(negedge clk);
        Reset = 1'b1;
        cyc = 0;
        while (!(memBus.mem_req && memBus.mem_addr == 16'h0040) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("ld_addr", memBus.mem_addr, 16'h0040);
        checkOutput("ld_we", memBus.mem_we, 0);
        checkOutput("ld_pc", PC, 16'h0001);
        checkOutput("ld_oprandb", {OprandB, WBresource}, 2'b11);
        @(negedge clk);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("abort_req", memBus.mem_req, 0);
        checkOutput("abort_pc", PC, 16'h0000);
        checkOutput("abort_addr", memBus.mem_addr, 16'h0000);
        checkOutput("abort_wbrf", WBRF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the simplified 16-bit RISC processor. It fetches instructions over a request/acknowledge memory port and holds them in an instruction register (IR). It sequences the register-file/ALU datapath through FETCH/DECODE/EXE/MEM/WB states and owns the PC, the PSW (C/Z/N) and the memory data register (MDR). It drives every datapath control strobe: WBRF, WBresource, RBresource, OprandB, LI, Buff_OutR, ALUop, Flag and PSW_C.

## Interface
- PC_RESET, 16'h0000, PC value loaded at reset.
- clk  in  1  system clock; all controller state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset (asserted when 0).
- mem_ack  in  1  memory completes the current request this cycle; may be combinational with mem_req.
- mem_rdata  in  16  read data, valid when mem_ack=1.
- Sum  in  16  datapath ALU result; used as the load/store address.
- C, Z, N  in  1 each  datapath ALU flags.
- mem_req, mem_we  out  1 each  memory request and write qualifier.
- mem_addr  out  16  PC during FETCH, Sum during MEM.
- Ins  out  11  IR[10:0] to the datapath.
- MEMData  out  16  MDR contents.
- WBRF, WBresource, RBresource, OprandB, LI, Buff_OutR, ALUop, Flag  out  1 each  datapath controls.
- WBsrc  out  1  external WBData mux select: 0 selects Sum, 1 selects LI_EXE.
- PSW_C, PSW_Z, PSW_N  out  1 each  PSW register.
- PC  out  16  program counter.
- halted  out  1  high while in HALT.
- illegal  out  1  one-cycle pulse in DECODE for an undefined opcode.

## Operation
- Instruction fields: opcode IR[15:11], Rd IR[10:8], Rm IR[7:5], Rn IR[4:2], imm5 IR[4:0], imm8 IR[7:0].
- Opcodes and per-instruction controls:
  - 00000 NOP.
  - 00001 ADD (ALUop=0), 00010 SUB (ALUop=1).
  - 00011 ADC (ALUop=0, Flag=1), 00100 SBB (ALUop=1, Flag=1).
  - 00101 ADDI, 00110 SUBI: OprandB=1.
  - 00111 LHI: LI=1, RBresource=1, WBsrc=1. 01000 LLI: LI=0, WBsrc=1.
  - 01001 LD: Rd=mem[Rm+imm5], OprandB=1, WBresource=1.
  - 01010 ST: mem[Rm+imm5]=Rd, OprandB=1, RBresource=1.
  - 01011 OUT: latch Rm into OutR.
  - 01100 CMP: flags of Rm−Rn, no writeback.
  - 01101 BZ: if PSW_Z, PC ← PC + sext(imm8).
  - 11111 HLT.
  - All other opcodes behave as NOP and assert illegal.
- Decoded controls (OprandB, RBresource, LI, ALUop, Flag, WBsrc, WBresource) are driven in DECODE, EXE, MEM and WB, and are 0 in FETCH and HALT. The datapath's operand registers reload on every falling edge, so these controls must stay stable for the whole instruction.
- States:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. Wait until mem_ack. On ack: IR ← mem_rdata, PC ← PC+1, go to DECODE.
  - DECODE:
    - OUT: Buff_OutR=1, then FETCH.
    - NOP/illegal: go to FETCH.
    - HLT: go to HALT.
    - All others: go to EXE.
  - EXE:
    - ALU ops, LHI, LLI: go to WB.
    - LD, ST: go to MEM.
    - CMP: PSW ← {C,Z,N}, then FETCH.
    - BZ: conditional PC update, then FETCH.
  - MEM: mem_req=1, mem_addr=Sum, mem_we=1 for ST. Wait until mem_ack. On ack: LD latches MDR ← mem_rdata and goes to WB; ST goes to FETCH.
  - WB: WBRF=1. At the end of WB, ALU ops (ADD through SUBI) also update PSW ← {C,Z,N}. Then FETCH. The PSW update is deferred to WB so that ADC/SBB Sum stays stable until the register-file write.
  - HALT: terminal; leaves only on reset.
- PC and BZ target arithmetic wrap modulo 2^16.

## Timing
- Reset asserted: state=FETCH, PC=PC_RESET, IR=0, MDR=0, PSW=000. All outputs are 0, including mem_req, and mem_addr=PC_RESET. mem_req rises in the first cycle after release.
- Reset mid-instruction aborts immediately: no RF write, no PSW update, any pending request is dropped.
- Zero-wait-state cycle counts: NOP/OUT 2, CMP/BZ 3, ALU/LHI/LLI/ST 4, LD 5. Each wait cycle (mem_req=1, mem_ack=0) adds one cycle.
- mem_req, mem_we and mem_addr are held constant until mem_ack.
- illegal is high for exactly the DECODE cycle.
- WBRF is high for exactly one cycle; the RF write and the PSW update occur on the same rising edge.

## Test plan
- Reset release, memory returns ADDI R1,R0,5 (0x2905) with zero wait → PC=1 after FETCH; OprandB=1 for 3 cycles; WBRF pulses in cycle 4; PSW=000.
- FETCH with mem_ack delayed 3 cycles → mem_req and mem_addr=0 held stable for 4 cycles; IR loads only on ack.
- Sum=0xFFFF, C=1, Z=0 on ADD, then ADC → PSW_C=1 only at the end of WB of ADD; ADC drives Flag=1 with the stable PSW_C.
- CMP with Z=1, then BZ imm8=0xFE at PC=0x0010 → PC=0x000F after BZ EXE; BZ with PSW_Z=0 → PC unchanged.
- LD with Sum=0x0040 and mem_rdata=0xBEEF → mem_addr=0x0040, mem_we=0, MDR=0xBEEF; WB drives WBRF=1, WBresource=1. ST → mem_we=1 with no WB.
- Opcode 10101 → illegal pulses once, then FETCH. HLT → halted=1 indefinitely. Reset low during MEM → mem_req drops asynchronously, PC=PC_RESET.
